// File: rtl/token_shaper_mc.sv
// Multi-channel token-bucket shaper with a round-robin single-grant arbiter.
// Optional per-channel grant counters are enabled by defining TOKEN_SHAPER_STATS_EN.
module token_shaper_mc #(
   parameter int NCH       = 4,
   parameter int DEN       = 16,
   parameter int RATE_NUM  = 3,
   parameter int BURST_MAX = 8,
   parameter int COST_W    = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [NCH-1:0]      req_i,
   input  logic [NCH*COST_W-1:0] cost_i,
   output logic [NCH-1:0]      grant_o,
   output logic [NCH-1:0]      ready_o
`ifdef TOKEN_SHAPER_STATS_EN
   ,
   output logic [NCH*16-1:0]   grant_cnt_o
`endif
);

   localparam int TOK_MAX = BURST_MAX * DEN;
   localparam int TOK_W   = $clog2(TOK_MAX + 1);
   localparam int SUM_W   = $clog2(TOK_MAX + RATE_NUM + 1);
   localparam int MAX_A   = (TOK_W > COST_W) ? TOK_W : COST_W;
   localparam int CMP_W   = ((MAX_A > SUM_W) ? MAX_A : SUM_W) + 1;
   localparam int PTR_W   = (NCH > 1) ? $clog2(NCH) : 1;

   localparam logic [CMP_W-1:0] TOK_MAX_C = CMP_W'(TOK_MAX);
   localparam logic [CMP_W-1:0] RATE_C    = CMP_W'(RATE_NUM);

   logic [TOK_W-1:0] tok  [NCH];
   logic [CMP_W-1:0] sum  [NCH];
   logic [CMP_W-1:0] post [NCH];
   logic [CMP_W-1:0] cost [NCH];
   logic [NCH-1:0]   elig;
   logic [NCH-1:0]   grant_nxt;
   logic [PTR_W-1:0] ptr;
   logic [PTR_W-1:0] ptr_nxt;
   logic [PTR_W-1:0] win;
   logic             win_vld;
   int               idx;

   // Costs are widened so any cost above TOK_MAX simply never qualifies.
   always_comb begin
      for (int c = 0; c < NCH; c++) begin
         cost[c]    = CMP_W'(cost_i[c*COST_W +: COST_W]);
         sum[c]     = CMP_W'(tok[c]) + RATE_C;
         post[c]    = (sum[c] > TOK_MAX_C) ? TOK_MAX_C : sum[c];
         ready_o[c] = (post[c] >= cost[c]);
      end
   end

   assign elig = req_i & ready_o;

   always_comb begin
      win_vld = 1'b0;
      win     = '0;
      idx     = 0;
      for (int i = 0; i < NCH; i++) begin
         idx = int'(ptr) + i;
         if (idx >= NCH) idx = idx - NCH;
         if (!win_vld && elig[idx]) begin
            win_vld = 1'b1;
            win     = PTR_W'(idx);
         end
      end
      ptr_nxt = (int'(win) == NCH - 1) ? '0 : win + PTR_W'(1);
      for (int c = 0; c < NCH; c++) begin
         grant_nxt[c] = win_vld && (win == PTR_W'(c));
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int c = 0; c < NCH; c++) tok[c] <= TOK_W'(TOK_MAX);
         grant_o <= '0;
         ptr     <= '0;
      end else begin
         for (int c = 0; c < NCH; c++) begin
            tok[c] <= grant_nxt[c] ? TOK_W'(post[c] - cost[c]) : TOK_W'(post[c]);
         end
         grant_o <= grant_nxt;
         if (win_vld) ptr <= ptr_nxt;
      end
   end

`ifdef TOKEN_SHAPER_STATS_EN
   logic [15:0] cnt [NCH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int c = 0; c < NCH; c++) cnt[c] <= '0;
      end else begin
         for (int c = 0; c < NCH; c++) begin
            if (grant_nxt[c] && (cnt[c] != 16'hFFFF)) cnt[c] <= cnt[c] + 16'd1;
         end
      end
   end

   for (genvar g = 0; g < NCH; g++) begin : g_cnt
      assign grant_cnt_o[g*16 +: 16] = cnt[g];
   end
`endif

endmodule

// File: doc/token_shaper_mc.md
TOKEN_SHAPER_MC -- requirements
Module: token_shaper_mc

Interface
REQ-001 Parameter NCH, default 4: number of request channels, 1..16.
REQ-002 Parameter DEN, default 16: token denominator (tokens per unit-cost request).
REQ-003 Parameter RATE_NUM, default 3: tokens added to every bucket per clock.
REQ-004 Parameter BURST_MAX, default 8: bucket depth in units of DEN, so TOK_MAX = BURST_MAX*DEN.
REQ-005 Parameter COST_W, default 8: width of the per-request cost field, in tokens.
REQ-006 Derived TOK_W = clog2(TOK_MAX+1): width of each bucket register.
REQ-007 clk  input  1  single clock; all state updates on the rising edge.
REQ-008 rst_n  input  1  asynchronous, active-low reset.
REQ-009 req_i  input  NCH  per-channel request level.
REQ-010 cost_i  input  NCH*COST_W  per-channel request cost in tokens; channel c occupies bits [c*COST_W +: COST_W].
REQ-011 grant_o  output  NCH  registered, one-hot or zero; grant pulse per channel.
REQ-012 ready_o  output  NCH  combinational; channel c would be eligible this cycle, ignoring arbitration.

Function
REQ-013 Each channel SHALL own one bucket tok[c] of width TOK_W.
REQ-014 Post-add value: post[c] = min(tok[c] + RATE_NUM, TOK_MAX), computed every cycle for every channel.
REQ-015 Eligibility: elig[c] = req_i[c] && (post[c] >= cost_i[c]).
REQ-016 Compare widths: cost_i SHALL be compared zero-extended, so cost > TOK_MAX is never eligible; the request holds with no grant and no error.
REQ-017 ready_o[c] SHALL equal (post[c] >= cost_i[c]), independent of req_i.
REQ-018 Arbitration: at most one grant per cycle, round-robin among elig, searching upward from pointer ptr with wrap at NCH-1 -> 0.
REQ-019 Winner w: at the rising edge, grant_o = one-hot(w), tok[w] <= post[w] - cost_i[w], ptr <= (w+1) mod NCH.
REQ-020 Non-winners: tok[c] <= post[c]; grant_o[c] = 0.
REQ-021 No eligible channel: grant_o <= 0, ptr unchanged, all tok[c] <= post[c].
REQ-022 Latency: a request sampled at edge N with sufficient post-add tokens and won arbitration shows grant_o high after edge N, for exactly one cycle per grant.
REQ-023 Held request: a channel keeping req_i high SHALL receive a fresh arbitration each cycle; a single grant is not sticky.
REQ-024 Zero cost: cost_i = 0 SHALL be eligible whenever requested and SHALL consume no tokens.
REQ-025 Saturation: buckets never exceed TOK_MAX and never underflow.

Reset
REQ-026 When rst_n is low, the block SHALL asynchronously set tok[c] = TOK_MAX for all c, grant_o = 0, ptr = 0, and stats counters = 0.
REQ-027 When rst_n is asserted mid-operation, grant_o SHALL drop without waiting for a clock edge; the first evaluation occurs at the first rising edge with rst_n high.

Configuration
REQ-028 Macro TOKEN_SHAPER_STATS_EN, when defined, SHALL add the output grant_cnt_o [NCH*16].
REQ-029 grant_cnt_o: one 16-bit counter per channel, +1 per grant, saturating at 0xFFFF, cleared only by reset.
REQ-030 When the macro is undefined, the port and counters SHALL be absent and all other behaviour SHALL be identical.

Verification (NCH=4, DEN=16, RATE_NUM=3, BURST_MAX=8, TOK_MAX=128)
REQ-031 Single channel: ch2 only, req high, cost 16 from reset release -> post sequence 128,115,...,24; 9 consecutive grants; no grant on cycle 10 (post=11); then long-run rate 3/16.
REQ-032 All four channels, req high, cost 16 -> grants ch0,ch1,ch2,ch3,ch0,... one per cycle until buckets deplete; long-run 3/16 per channel, total 0.75 grants/cycle.
REQ-033 Round-robin: ptr=2, only ch1 and ch3 eligible -> ch3 granted; next cycle ch1 granted (ptr=0).
REQ-034 Unserviceable cost: ch0 cost 200 held for 100 cycles -> grant_o[0]=0 and ready_o[0]=0 throughout; other channels unaffected.
REQ-035 Reset mid-burst: drop rst_n for 2 cycles during REQ-032 traffic -> grant_o=0 at once; after release first grant is ch0 with all buckets at 128.
REQ-036 With TOKEN_SHAPER_STATS_EN: after REQ-031, grant_cnt_o[ch2] equals the scoreboard grant count and the other counters are 0.
